// File: rtl/vau_result_drain.sv
// Readout side of the 4-lane vector FP ALU: waits a settle time after start,
// snapshots result and flags, then streams lane 0..3 and a status word over valid/ready.
module vau_result_drain #(
    parameter int unsigned LANES         = 4,
    parameter int unsigned WORD_W        = 32,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [LANES*WORD_W-1:0]   i_alu_result,
    input  logic [LANES-1:0]          i_exception,
    input  logic [LANES-1:0]          i_overflow,
    input  logic [LANES-1:0]          i_underflow,
    output logic [WORD_W-1:0]         o_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_last,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int unsigned SNAP_W = LANES * WORD_W;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CNT_W  = 4;
    localparam bit          SKIP_SETTLE = (SETTLE_CYCLES == 0);
    localparam logic [CNT_W-1:0] SETTLE_LAST =
        CNT_W'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        SEND,
        DONE
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    settle_cnt;
    logic [IDX_W-1:0]    idx;
    logic [SNAP_W-1:0]   snap;
    logic [WORD_W-1:0]   status;

    // Beat index 0..LANES-1 selects a snapshot lane, LANES selects the status word.
    function automatic logic [WORD_W-1:0] beat_word(
        input logic [IDX_W-1:0]  sel,
        input logic [SNAP_W-1:0] lanes,
        input logic [WORD_W-1:0] stat
    );
        if (sel == LAST_IDX) begin
            return stat;
        end
        return lanes[32'(sel) * WORD_W +: WORD_W];
    endfunction

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            idx        <= '0;
            snap       <= '0;
            status     <= '0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_last     <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        settle_cnt <= '0;
                        o_busy     <= 1'b1;
                        state      <= SKIP_SETTLE ? CAPTURE : SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end
                CAPTURE: begin
                    // First beat is driven straight from the inputs being snapshotted.
                    snap    <= i_alu_result;
                    status  <= WORD_W'({i_underflow, i_overflow, i_exception});
                    idx     <= '0;
                    o_data  <= i_alu_result[WORD_W-1:0];
                    o_valid <= 1'b1;
                    o_last  <= 1'b0;
                    state   <= SEND;
                end
                SEND: begin
                    if (i_ready) begin
                        if (idx == LAST_IDX) begin
                            o_data  <= '0;
                            o_valid <= 1'b0;
                            o_last  <= 1'b0;
                            state   <= DONE;
                        end else begin
                            idx    <= idx + IDX_W'(1);
                            o_data <= beat_word(idx + IDX_W'(1), snap, status);
                            o_last <= ((idx + IDX_W'(1)) == LAST_IDX);
                        end
                    end
                end
                DONE: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vau_result_drain.sv
// Self-checking bench for vau_result_drain: table vectors, random vectors against a
// beat-list model, backpressure, late input changes, ignored starts and mid-transfer reset.
module tb_vau_result_drain;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, start_z;
    logic [127:0] result;
    logic [3:0]   ex, ov, uf;
    logic         ready, ready_z;
    logic [31:0]  data, data_z;
    logic         valid, valid_z, last, last_z, busy, busy_z, done, done_z;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vau_result_drain #(.LANES(4), .WORD_W(32), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .i_rst(rst), .i_start(start), .i_alu_result(result),
        .i_exception(ex), .i_overflow(ov), .i_underflow(uf),
        .o_data(data), .o_valid(valid), .i_ready(ready), .o_last(last),
        .o_busy(busy), .o_done(done)
    );

    vau_result_drain #(.LANES(4), .WORD_W(32), .SETTLE_CYCLES(0)) dut_z (
        .clk(clk), .i_rst(rst), .i_start(start_z), .i_alu_result(result),
        .i_exception(ex), .i_overflow(ov), .i_underflow(uf),
        .o_data(data_z), .o_valid(valid_z), .i_ready(ready_z), .o_last(last_z),
        .o_busy(busy_z), .o_done(done_z)
    );

    typedef struct {
        logic [127:0] res;
        logic [3:0]   ex, ov, uf;
        int           mode;
        bit           poke;
        bit           corrupt;
        logic [159:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected beat list: four 32-bit lanes of the result, then the flag status word.
    function automatic logic [159:0] model(input logic [127:0] r, input logic [3:0] e,
                                           input logic [3:0] o, input logic [3:0] u);
        logic [159:0] m;
        logic [127:0] sh;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            sh = r >> (32 * i);
            m[32*i +: 32] = sh[31:0];
        end
        m[159:128] = 32'(u) * 256 + 32'(o) * 16 + 32'(e);
        return m;
    endfunction

    function automatic logic ready_for(input int mode, input int c);
        logic [5:0] pat;
        pat = 6'b101001;
        case (mode)
            0: return 1'b1;
            1: return pat[c % 6];
            default: return ($urandom % 4) != 0;
        endcase
    endfunction

    // Runs one transfer from a posedge+1 alignment and checks it end to end.
    task automatic run_xfer(input vec_t v);
        int           c, beats, done_cnt, first_v, done_c;
        logic         prev_stall, prev_last, hs;
        logic [31:0]  prev_data;
        result = v.res; ex = v.ex; ov = v.ov; uf = v.uf;
        start  = 1'b1;
        ready  = ready_for(v.mode, 0);
        @(posedge clk); #1;
        start = 1'b0;
        c = 1; beats = 0; done_cnt = 0; first_v = -1; done_c = -1;
        prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
        while (c < 80 && !(done_c >= 0 && c >= done_c + 3)) begin
            if (prev_stall) begin
                chk("hold_valid", 160'(valid), 160'(1));
                chk("hold_data", 160'(data), 160'(prev_data));
                chk("hold_last", 160'(last), 160'(prev_last));
            end
            if (!valid) chk("data_zero_idle", 160'(data), 160'(0));
            if (done_c < 0 && !done) chk("busy_high", 160'(busy), 160'(1));
            if (done_c >= 0 && c > done_c) chk("no_restart", 160'(valid), 160'(0));
            if (valid && first_v < 0) first_v = c;
            if (done) begin
                done_cnt++;
                if (done_c < 0) done_c = c;
            end
            if (v.corrupt && valid) result = '1;
            start = (v.poke && valid && beats == 2);
            ready = ready_for(v.mode, c);
            hs = valid && ready;
            if (hs) begin
                if (beats < 5) begin
                    chk($sformatf("beat%0d_data", beats), 160'(data), 160'(v.exp[32*beats +: 32]));
                    chk($sformatf("beat%0d_last", beats), 160'(last), 160'(beats == 4));
                end else begin
                    chk("extra_beat", 160'(beats), 160'(4));
                end
                beats++;
            end
            prev_stall = valid && !ready;
            prev_data  = data;
            prev_last  = last;
            @(posedge clk); #1;
            c++;
        end
        start = 1'b0;
        chk("beat_count", 160'(beats), 160'(5));
        chk("done_count", 160'(done_cnt), 160'(1));
        chk("end_busy", 160'(busy), 160'(0));
        if (v.mode == 0) begin
            chk("first_valid_latency", 160'(first_v), 160'(4));
            chk("done_latency", 160'(done_c), 160'(10));
        end
    endtask

    vec_t tbl[5];
    vec_t rv;

    initial begin
        rst = 1'b1; start = 1'b0; start_z = 1'b0; ready = 1'b0; ready_z = 1'b0;
        result = '0; ex = '0; ov = '0; uf = '0;

        tbl[0] = '{128'h40400000_3F800000_C0000000_41200000, 4'h0, 4'h0, 4'h0, 0, 1'b0, 1'b0,
                   {32'h00000000, 32'h40400000, 32'h3F800000, 32'hC0000000, 32'h41200000}};
        tbl[1] = '{128'h11111111_22222222_33333333_44444444, 4'b0001, 4'b1000, 4'b0100, 0, 1'b0, 1'b0,
                   {32'h00000481, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}};
        tbl[2] = '{128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 4'b1111, 4'b0000, 4'b0000, 1, 1'b0, 1'b0,
                   {32'h0000000F, 32'hDEADBEEF, 32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF}};
        tbl[3] = '{128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 4'b0000, 4'b0110, 4'b0000, 0, 1'b0, 1'b1,
                   {32'h00000060, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F, 32'hF0F0F0F0}};
        tbl[4] = '{128'h00000004_00000003_00000002_00000001, 4'b0000, 4'b0000, 4'b1111, 1, 1'b1, 1'b0,
                   {32'h00000F00, 32'h00000004, 32'h00000003, 32'h00000002, 32'h00000001}};

        #1;
        chk("reset_data", 160'(data), 160'(0));
        chk("reset_valid", 160'(valid), 160'(0));
        chk("reset_last", 160'(last), 160'(0));
        chk("reset_busy", 160'(busy), 160'(0));
        chk("reset_done", 160'(done), 160'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) run_xfer(tbl[i]);

        // Reset while the third beat (index 2) is on the bus.
        result = tbl[0].res; ex = '0; ov = '0; uf = '0;
        start = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 6; c++) begin
            @(posedge clk); #1;
        end
        chk("pre_reset_beat2", 160'(data), 160'(32'h3F800000));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 160'(valid), 160'(0));
        chk("async_rst_data", 160'(data), 160'(0));
        chk("async_rst_last", 160'(last), 160'(0));
        chk("async_rst_busy", 160'(busy), 160'(0));
        chk("async_rst_done", 160'(done), 160'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("no_done_after_rst", 160'(done), 160'(0));
            chk("idle_after_rst", 160'(valid), 160'(0));
            @(posedge clk); #1;
        end
        run_xfer(tbl[1]);

        // Randomized vectors against the beat-list model.
        for (int k = 0; k < 20; k++) begin
            rv.res = {$urandom, $urandom, $urandom, $urandom};
            rv.ex = 4'($urandom); rv.ov = 4'($urandom); rv.uf = 4'($urandom);
            rv.mode = int'($urandom % 3);
            rv.poke = 1'($urandom);
            rv.corrupt = 1'($urandom);
            rv.exp = model(rv.res, rv.ex, rv.ov, rv.uf);
            run_xfer(rv);
        end

        // Zero-settle build: first beat two cycles after start, done eight cycles after.
        begin
            int c, beats, fv, dc;
            result = tbl[1].res; ex = tbl[1].ex; ov = tbl[1].ov; uf = tbl[1].uf;
            start_z = 1'b1; ready_z = 1'b1;
            @(posedge clk); #1;
            start_z = 1'b0;
            c = 1; beats = 0; fv = -1; dc = -1;
            while (c < 40 && dc < 0) begin
                if (valid_z && fv < 0) fv = c;
                if (done_z) dc = c;
                if (valid_z && ready_z) begin
                    if (beats < 5)
                        chk($sformatf("z_beat%0d", beats), 160'(data_z), 160'(tbl[1].exp[32*beats +: 32]));
                    beats++;
                end
                @(posedge clk); #1;
                c++;
            end
            chk("z_first_valid_latency", 160'(fv), 160'(2));
            chk("z_done_latency", 160'(dc), 160'(8));
            chk("z_beat_count", 160'(beats), 160'(5));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
